// File: rtl/clarke_sched.sv
// clarke_sched: round-robin front end that lets N_REQ requesters share one
// Clarke transform unit. It accepts one (a, b) pair at a time, pulses the
// unit's start for a single cycle, waits a fixed LATENCY, captures alpha/beta,
// and returns them tagged with the owning requester ID.
//
// Ports
//   clk                 clock, rising edge
//   rstb                asynchronous active-low reset
//   req_valid[N_REQ]    per-requester sample present
//   req_ready[N_REQ]    per-requester accept (one-hot, IDLE only)
//   req_a/req_b         packed samples, requester i at [i*D_WIDTH +: D_WIDTH]
//   cl_start            one-cycle start strobe to the Clarke unit
//   cl_a/cl_b           operands to the Clarke unit (held after start)
//   cl_alpha/cl_beta    results from the Clarke unit
//   rsp_valid/rsp_ready response handshake
//   rsp_id              requester that owns the response
//   rsp_alpha/rsp_beta  captured results
//   busy                a transaction is in flight
module clarke_sched #(
    parameter int D_WIDTH = 18,
    parameter int N_REQ   = 2,
    parameter int LATENCY = 1,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*D_WIDTH-1:0]   req_a,
    input  logic [N_REQ*D_WIDTH-1:0]   req_b,
    output logic                       cl_start,
    output logic [D_WIDTH-1:0]         cl_a,
    output logic [D_WIDTH-1:0]         cl_b,
    input  logic [D_WIDTH-1:0]         cl_alpha,
    input  logic [D_WIDTH-1:0]         cl_beta,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [D_WIDTH-1:0]         rsp_alpha,
    output logic [D_WIDTH-1:0]         rsp_beta,
    output logic                       busy
);

    // Counter only has to hold LATENCY-1.
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [LAT_W-1:0]   lat_cnt_q,   lat_cnt_d;
    logic [D_WIDTH-1:0] op_a_q,      op_a_d;
    logic [D_WIDTH-1:0] op_b_q,      op_b_d;
    logic [ID_W-1:0]    op_id_q,     op_id_d;
    logic               cl_start_q,  cl_start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
    logic [D_WIDTH-1:0] rsp_alpha_q, rsp_alpha_d;
    logic [D_WIDTH-1:0] rsp_beta_q,  rsp_beta_d;
    logic               busy_q,      busy_d;

    logic [ID_W-1:0]    grant_s;
    logic               grant_vld_s;
    logic               accept_s;
    logic [N_REQ-1:0]   req_ready_s;

    // Round-robin arbiter: scan from rr_ptr+N down to rr_ptr+1 so the candidate
    // closest after rr_ptr is written last and therefore wins.
    always_comb begin
        logic [ID_W-1:0] idx_v;
        grant_s     = '0;
        grant_vld_s = 1'b0;
        idx_v       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx_v       = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            grant_vld_s = grant_vld_s | req_valid[idx_v];
            grant_s     = req_valid[idx_v] ? idx_v : grant_s;
        end
    end

    // Accept decode; rstb gates ready so nothing is offered while held in reset.
    always_comb begin
        req_ready_s = '0;
        accept_s    = rstb && (state_q == IDLE) && grant_vld_s;
        if (accept_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lat_cnt_d   = lat_cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        cl_start_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_alpha_d = rsp_alpha_q;
        rsp_beta_d  = rsp_beta_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_a_d     = req_a[int'(grant_s)*D_WIDTH +: D_WIDTH];
                    op_b_d     = req_b[int'(grant_s)*D_WIDTH +: D_WIDTH];
                    op_id_d    = grant_s;
                    rr_ptr_d   = grant_s;
                    // Registered strobe so it is high exactly while in START.
                    cl_start_d = 1'b1;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                lat_cnt_d = LAT_W'(LATENCY - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                // The unit's done is sticky, so completion is counted, not observed.
                if (lat_cnt_q == '0) begin
                    rsp_alpha_d = cl_alpha;
                    rsp_beta_d  = cl_beta;
                    rsp_id_d    = op_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ID_W'(N_REQ - 1);
            lat_cnt_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            cl_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_alpha_q <= '0;
            rsp_beta_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lat_cnt_q   <= lat_cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            cl_start_q  <= cl_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_alpha_q <= rsp_alpha_d;
            rsp_beta_q  <= rsp_beta_d;
            busy_q      <= busy_d;
        end
    end

    // Operand registers feed the unit directly and hold through WAIT.
    assign cl_a      = op_a_q;
    assign cl_b      = op_b_q;
    assign cl_start  = cl_start_q;
    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_alpha = rsp_alpha_q;
    assign rsp_beta  = rsp_beta_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_clarke_sched.sv
module tb_clarke_sched;

    localparam int DW = 18;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*DW-1:0]      req_a;
    logic [2*DW-1:0]      req_b;
    logic                 cl_start;
    logic signed [DW-1:0] cl_a, cl_b;
    logic signed [DW-1:0] cl_alpha, cl_beta;
    logic                 cl_done;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [0:0]           rsp_id;
    logic signed [DW-1:0] rsp_alpha, rsp_beta;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    typedef struct {
        int id;
        int alpha;
        int beta;
    } exp_t;
    exp_t sb[$];

    clarke_sched #(.D_WIDTH(DW), .N_REQ(2), .LATENCY(1)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .cl_start(cl_start), .cl_a(cl_a), .cl_b(cl_b),
        .cl_alpha(cl_alpha), .cl_beta(cl_beta),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_alpha(rsp_alpha), .rsp_beta(rsp_beta),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Clarke unit stand-in: alpha = a, beta = (a + 2b) * 18918 >> 15 (Q15 1/sqrt3),
    // one cycle latency, sticky done.
    function automatic logic signed [DW-1:0] beta_f(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        longint s;
        s = (longint'(a) + 2 * longint'(b)) * 18918;
        return DW'(s >>> 15);
    endfunction

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cl_alpha <= '0;
            cl_beta  <= '0;
            cl_done  <= 1'b0;
        end else if (cl_start) begin
            cl_alpha <= cl_a;
            cl_beta  <= beta_f(cl_a, cl_b);
            cl_done  <= 1'b1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every accepted response with the queue head.
    always @(negedge clk) begin
        if (rstb && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_alpha", rsp_alpha, e.alpha);
                chk("rsp_beta", rsp_beta, e.beta);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input int a, input int b);
        req_a[idx*DW +: DW] = DW'(a);
        req_b[idx*DW +: DW] = DW'(b);
    endtask

    task automatic push(input int id, input int alpha, input int beta);
        exp_t e;
        e.id = id; e.alpha = alpha; e.beta = beta;
        sb.push_back(e);
    endtask

    // Single transaction with cycle-exact checks; called at posedge+1, returns at
    // posedge+1 of the cycle after the response handshake.
    task automatic do_single(input int idx, input int a, input int b,
                             input int ea, input int eb);
        set_req(idx, a, b);
        req_valid = 2'(1 << idx);
        @(negedge clk);
        chk("accept_ready", req_ready, 1 << idx);
        push(idx, ea, eb);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("start_pulse", cl_start, 1);
        chk("start_cl_a", cl_a, a);
        chk("start_cl_b", cl_b, b);
        chk("busy_start", busy, 1);
        tick();
        @(negedge clk);
        chk("wait_start_low", cl_start, 0);
        chk("wait_no_rsp", rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("rsp_valid_c3", rsp_valid, 1);
        tick();
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 12) begin
            @(negedge clk);
            ok = (req_ready != 2'b00);
            n++;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 12) begin
            @(negedge clk);
            ok = rsp_valid;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = !busy;
            n++;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int last_acc;
        rstb      = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset values, with both requesters asserting valid.
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cl_start", cl_start, 0);
        chk("rst_cl_a", cl_a, 0);
        chk("rst_cl_b", cl_b, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_alpha", rsp_alpha, 0);
        chk("rst_rsp_beta", rsp_beta, 0);
        tick();
        req_valid = 2'b00;
        rstb = 1'b1;
        tick();

        // 1: single request, requester 0.
        do_single(0, 16384, 0, 16384, 9459);
        @(negedge clk);
        chk("idle_after_1", busy, 0);
        tick();

        // 2: negative operands, requester 1.
        do_single(1, -16384, -16384, -16384, -28377);

        // 3: round-robin with both valid.
        set_req(0, 1000, 2000);
        set_req(1, -3000, 500);
        req_valid = 2'b11;
        last_acc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(ok);
            if (!ok) begin
                chk("rr_grant_timeout", 0, 1);
            end else begin
                chk("rr_grant", req_ready, (k % 2 == 0) ? 1 : 2);
                if (k % 2 == 0) push(0, 1000, 2886);
                else            push(1, -3000, -1155);
                if (k > 0) chk("rr_spacing", cyc_cnt - last_acc, 4);
                last_acc = cyc_cnt;
            end
            tick();
        end
        req_valid = 2'b00;
        wait_idle();

        // 4: backpressure.
        rsp_ready = 1'b0;
        set_req(0, -5, 7);
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_accept", req_ready, 1);
        push(0, -5, 5);
        tick();
        set_req(1, 123, -456);
        req_valid = 2'b11;
        wait_rsp(ok);
        if (!ok) chk("bp_rsp_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_rsp_alpha", rsp_alpha, -5);
            chk("bp_rsp_beta", rsp_beta, 5);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_cl_start", cl_start, 0);
            tick();
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_next_grant", req_ready, 2);
        push(1, 123, -456);
        tick();
        req_valid = 2'b00;
        wait_idle();

        // 5: reset while in WAIT.
        set_req(0, 777, 0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("rw_accept", req_ready, 1);
        tick();
        req_valid = 2'b00;
        tick();
        rstb = 1'b0;
        set_req(0, 2000, 1000);
        set_req(1, 55, 66);
        req_valid = 2'b11;
        @(negedge clk);
        chk("rw_busy", busy, 0);
        chk("rw_req_ready", req_ready, 0);
        chk("rw_cl_start", cl_start, 0);
        chk("rw_cl_a", cl_a, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_rsp_alpha", rsp_alpha, 0);
        tick();
        @(negedge clk);
        chk("rw_rsp_valid2", rsp_valid, 0);
        tick();
        rstb = 1'b1;
        @(negedge clk);
        chk("rw_first_grant", req_ready, 1);
        push(0, 2000, 2309);
        tick();
        req_valid = 2'b00;
        wait_idle();

        // 6: back-to-back transactions with sticky done.
        do_single(1, 300, 400, 300, 635);
        do_single(0, -600, 50, -600, -289);
        chk("done_sticky", cl_done, 1);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clarke_sched.md
# clarke_sched

Round-robin scheduler that shares one `clarke` transform instance between `N_REQ` requesters, such as several phase-current channels or motor axes. It accepts (a, b) sample pairs over per-requester valid/ready handshakes. For each accepted pair it drives the Clarke unit's `start`, `a` and `b` inputs for exactly one cycle, waits a fixed latency, and captures alpha and beta. It then returns the result, tagged with the requester ID, over a single valid/ready response port.

## Interface
- `D_WIDTH`, 18, sample and result width (signed, Q_BITS fractional; must match the attached clarke).
- `N_REQ`, 2, number of requesters (at least 2).
- `LATENCY`, 1, cycles from `cl_start` high until `cl_alpha`/`cl_beta` are valid (at least 1).
- `ID_W`, `$clog2(N_REQ)`, requester ID width.

Reset is asynchronous and active-low.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rstb` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: bit i means requester i presents a sample.
- `req_ready` out N_REQ: bit i means requester i's sample is accepted this cycle.
- `req_a` in N_REQ*D_WIDTH: requester i's a sample at `[i*D_WIDTH +: D_WIDTH]`.
- `req_b` in N_REQ*D_WIDTH: requester i's b sample, packed the same way.
- `cl_start` out 1: start strobe to the Clarke unit.
- `cl_a`, `cl_b` out D_WIDTH each: operands to the Clarke unit.
- `cl_alpha`, `cl_beta` in D_WIDTH each: results from the Clarke unit.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out ID_W: index of the requester that owns the response.
- `rsp_alpha`, `rsp_beta` out D_WIDTH each: captured results.
- `busy` out 1: high in any state other than IDLE.

The Clarke unit's `done` output is not connected. It is sticky, so completion is timed by `LATENCY` only.

## Operation
FSM states are IDLE, START, WAIT and RESP.

- **IDLE:**
  - `grant` is the first index with `req_valid` high, searching upward from `rr_ptr+1` modulo N_REQ.
  - `req_ready[grant]` is driven high combinationally. All other `req_ready` bits are 0, and all bits are 0 outside IDLE.
  - On handshake: latch `req_a`/`req_b` slice and grant index into `op_a`, `op_b`, `op_id`; set `rr_ptr <= grant`; go to START.
  - With no `req_valid` bit high: stay in IDLE.
- **START:**
  - `cl_start`=1, `cl_a`=`op_a`, `cl_b`=`op_b` for exactly this one cycle.
  - Load `lat_cnt <= LATENCY-1`; go to WAIT.
- **WAIT:**
  - `cl_start`=0; `cl_a`/`cl_b` hold their last values.
  - If `lat_cnt`==0: capture `cl_alpha`, `cl_beta` and `op_id` into the `rsp_*` registers; set `rsp_valid <= 1`; go to RESP.
  - Otherwise decrement `lat_cnt`.
- **RESP:**
  - `rsp_valid`=1; `rsp_*` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake: `rsp_valid <= 0`; go to IDLE.
- No arithmetic is done in this block; data passes through unmodified at D_WIDTH bits.
- Requester samples may change freely except in the handshake cycle.
- There is exactly one transaction in flight. No request is accepted while `busy`=1.

## Timing
- **Reset values:**
  - state IDLE; `rr_ptr` = N_REQ-1, so requester 0 wins first.
  - `lat_cnt`, `op_a`, `op_b`, `op_id` = 0.
  - `cl_start`=0; `cl_a`, `cl_b` = 0.
  - `rsp_valid`=0; `rsp_id`, `rsp_alpha`, `rsp_beta` = 0.
  - `busy`=0; `req_ready` = 0 while `rstb` is low.
- **Cycle timing with accept in cycle 0:**
  - `cl_start` high in cycle 1.
  - Capture at the end of cycle 1+LATENCY.
  - `rsp_valid` high from cycle 2+LATENCY.
  - With LATENCY=1: response visible in cycle 3.
- **Throughput:** at best one transaction per 3+LATENCY cycles. The next accept is possible in the cycle after the response handshake.
- **Simultaneous requests:** exactly one grant per accept. A requester that keeps `req_valid` high waits at most N_REQ-1 other transactions.
- **`rsp_ready` low:** RESP persists indefinitely and all `req_ready` bits stay 0.
- **Reset mid-operation:** any state returns to the reset values immediately. The in-flight transaction is dropped with no response. Requesters must re-present the sample.
- **`req_valid` dropped before grant:** no effect; a sample is consumed only on handshake.

## Test plan
Tests use the real clarke (D_WIDTH=18, Q_BITS=15), N_REQ=2, LATENCY=1.

1. **Single request:** requester 0 presents a=16384, b=0, `rsp_ready`=1.
   - `req_ready[0]` is high in cycle 0 and `cl_start` in cycle 1.
   - `rsp_valid` is high in cycle 3 with `rsp_id`=0, `rsp_alpha`=16384, `rsp_beta`=9459.
2. **Negative operands:** requester 1 presents a=-16384, b=-16384.
   - Response is `rsp_id`=1, `rsp_alpha`=-16384, `rsp_beta`=-28377.
3. **Round-robin:** both requesters hold `req_valid` high with distinct samples for 4 transactions.
   - Grant order is 0,1,0,1, with 4 cycles between accepts.
   - Each `rsp_id` matches its data.
4. **Backpressure:** `rsp_ready` is held low for 5 cycles after `rsp_valid` rises.
   - `rsp_*` stay stable, `req_ready` stays 00 and `cl_start` stays 0.
   - On release the handshake completes and the next grant follows in the next cycle.
5. **Reset in WAIT:** `rstb` is pulled low during WAIT.
   - All outputs are at reset values while low, and no response is emitted.
   - After release, with both requesters valid, requester 0 is granted first.
6. **Sticky done ignored:** run two back-to-back transactions.
   - The second capture occurs exactly LATENCY cycles after its `cl_start`, even though the Clarke unit's `done` stays high.
   - Verify the second result is its own, not stale data.
